// File: rtl/wb_stage.sv
// Dual-lane writeback stage: in-order result queue that accepts up to two
// execute results per cycle and drains up to two registered regfile writes.
module wb_stage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SID_W = 6
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             inst0_exe_valid_i,
    input  logic [1:0]       inst0_exe_rd_type_i,
    input  logic [4:0]       inst0_exe_rd_i,
    input  logic [63:0]      inst0_exe_value_i,
    input  logic [SID_W-1:0] inst0_exe_sid_i,

    input  logic             inst1_exe_valid_i,
    input  logic [1:0]       inst1_exe_rd_type_i,
    input  logic [4:0]       inst1_exe_rd_i,
    input  logic [63:0]      inst1_exe_value_i,
    input  logic [SID_W-1:0] inst1_exe_sid_i,

    output logic             exe_ready_o,

    output logic             inst0_wb_valid_o,
    output logic [4:0]       inst0_wb_rd_o,
    output logic [63:0]      inst0_wb_value_o,
    output logic             inst1_wb_valid_o,
    output logic [4:0]       inst1_wb_rd_o,
    output logic [63:0]      inst1_wb_value_o,

    output logic             inst0_wb_sid_valid_o,
    output logic [SID_W-1:0] inst0_wb_sid_o,
    output logic             inst1_wb_sid_valid_o,
    output logic [SID_W-1:0] inst1_wb_sid_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [1:0]       rd_type;
        logic [4:0]       rd;
        logic [63:0]      value;
        logic [SID_W-1:0] sid;
    } entry_t;

    entry_t           entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    entry_t           lane0;
    entry_t           lane1;
    entry_t           ent_a;
    entry_t           ent_b;
    logic             enq0;
    logic             enq1;
    logic [CNT_W-1:0] enq_n;
    logic [CNT_W-1:0] deq_n;
    logic [PTR_W-1:0] tail_p1;
    logic             wr_a;
    logic             wr_b;
    logic             collide;

    // Readiness looks only at the registered count; a same-cycle drain earns no credit.
    assign exe_ready_o = !rst && (count <= CNT_W'(DEPTH - 2));

    always_comb begin
        lane0   = '{rd_type: inst0_exe_rd_type_i, rd: inst0_exe_rd_i,
                    value: inst0_exe_value_i, sid: inst0_exe_sid_i};
        lane1   = '{rd_type: inst1_exe_rd_type_i, rd: inst1_exe_rd_i,
                    value: inst1_exe_value_i, sid: inst1_exe_sid_i};
        enq0    = exe_ready_o && inst0_exe_valid_i;
        enq1    = exe_ready_o && inst1_exe_valid_i;
        enq_n   = CNT_W'(enq0) + CNT_W'(enq1);
        deq_n   = (count > CNT_W'(2)) ? CNT_W'(2) : count;
        tail_p1 = tail + PTR_W'(1);
        ent_a   = entries[head];
        ent_b   = entries[head + PTR_W'(1)];
        wr_a    = (ent_a.rd_type != 2'd0) && (ent_a.rd != 5'd0);
        wr_b    = (ent_b.rd_type != 2'd0) && (ent_b.rd != 5'd0);
        // Two drained writes to one rd: the younger (port 1) wins.
        collide = (deq_n == CNT_W'(2)) && wr_a && wr_b && (ent_a.rd == ent_b.rd);
    end

    // Result storage; the older lane always lands at tail.
    always_ff @(posedge clk) begin
        if (enq0 || enq1) begin
            entries[tail] <= enq0 ? lane0 : lane1;
        end
        if (enq0 && enq1) begin
            entries[tail_p1] <= lane1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            inst0_wb_valid_o     <= 1'b0;
            inst0_wb_rd_o        <= '0;
            inst0_wb_value_o     <= '0;
            inst0_wb_sid_valid_o <= 1'b0;
            inst0_wb_sid_o       <= '0;
            inst1_wb_valid_o     <= 1'b0;
            inst1_wb_rd_o        <= '0;
            inst1_wb_value_o     <= '0;
            inst1_wb_sid_valid_o <= 1'b0;
            inst1_wb_sid_o       <= '0;
        end else begin
            head  <= head + PTR_W'(deq_n);
            tail  <= tail + PTR_W'(enq_n);
            count <= count + enq_n - deq_n;

            inst0_wb_valid_o     <= 1'b0;
            inst0_wb_sid_valid_o <= 1'b0;
            inst1_wb_valid_o     <= 1'b0;
            inst1_wb_sid_valid_o <= 1'b0;

            if (deq_n != CNT_W'(0)) begin
                inst0_wb_valid_o     <= wr_a && !collide;
                inst0_wb_rd_o        <= ent_a.rd;
                inst0_wb_value_o     <= ent_a.value;
                inst0_wb_sid_valid_o <= 1'b1;
                inst0_wb_sid_o       <= ent_a.sid;
            end
            if (deq_n == CNT_W'(2)) begin
                inst1_wb_valid_o     <= wr_b;
                inst1_wb_rd_o        <= ent_b.rd;
                inst1_wb_value_o     <= ent_b.value;
                inst1_wb_sid_valid_o <= 1'b1;
                inst1_wb_sid_o       <= ent_b.sid;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a reference queue model predicts every
// cycle's writeback outputs and each scenario task compares against it.
module tb_wb_stage;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SID_W = 6;

    typedef struct packed {
        logic [1:0]       rd_type;
        logic [4:0]       rd;
        logic [63:0]      value;
        logic [SID_W-1:0] sid;
    } ent_t;

    typedef struct packed {
        logic             v0;
        logic [4:0]       rd0;
        logic [63:0]      val0;
        logic             sv0;
        logic [SID_W-1:0] sid0;
        logic             v1;
        logic [4:0]       rd1;
        logic [63:0]      val1;
        logic             sv1;
        logic [SID_W-1:0] sid1;
    } ports_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_valid = 1'b0, b_valid = 1'b0;
    logic [1:0]       a_type = '0, b_type = '0;
    logic [4:0]       a_rd = '0, b_rd = '0;
    logic [63:0]      a_val = '0, b_val = '0;
    logic [SID_W-1:0] a_sid = '0, b_sid = '0;

    logic             exe_ready;
    logic             w0_v, w1_v, s0_v, s1_v;
    logic [4:0]       w0_rd, w1_rd;
    logic [63:0]      w0_val, w1_val;
    logic [SID_W-1:0] s0_sid, s1_sid;

    int     total = 0;
    int     bad   = 0;
    ent_t   sbq[$];
    ports_t exp_p = '0;
    logic   obs_ready;
    logic   exp_ready;

    always #5 clk = ~clk;

    wb_stage #(.DEPTH(DEPTH), .SID_W(SID_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .inst0_exe_valid_i    (a_valid),
        .inst0_exe_rd_type_i  (a_type),
        .inst0_exe_rd_i       (a_rd),
        .inst0_exe_value_i    (a_val),
        .inst0_exe_sid_i      (a_sid),
        .inst1_exe_valid_i    (b_valid),
        .inst1_exe_rd_type_i  (b_type),
        .inst1_exe_rd_i       (b_rd),
        .inst1_exe_value_i    (b_val),
        .inst1_exe_sid_i      (b_sid),
        .exe_ready_o          (exe_ready),
        .inst0_wb_valid_o     (w0_v),
        .inst0_wb_rd_o        (w0_rd),
        .inst0_wb_value_o     (w0_val),
        .inst1_wb_valid_o     (w1_v),
        .inst1_wb_rd_o        (w1_rd),
        .inst1_wb_value_o     (w1_val),
        .inst0_wb_sid_valid_o (s0_v),
        .inst0_wb_sid_o       (s0_sid),
        .inst1_wb_sid_valid_o (s1_v),
        .inst1_wb_sid_o       (s1_sid)
    );

    function automatic ports_t dut_ports();
        return '{v0: w0_v, rd0: w0_rd, val0: w0_val, sv0: s0_v, sid0: s0_sid,
                 v1: w1_v, rd1: w1_rd, val1: w1_val, sv1: s1_v, sid1: s1_sid};
    endfunction

    // Drive one cycle of inputs, then advance the reference model across the edge.
    task automatic step(input logic r, input logic av, input ent_t ae,
                        input logic bv, input ent_t be);
        ent_t e0, e1;
        int   n;
        logic acc;
        rst = r;
        a_valid = av; a_type = ae.rd_type; a_rd = ae.rd; a_val = ae.value; a_sid = ae.sid;
        b_valid = bv; b_type = be.rd_type; b_rd = be.rd; b_val = be.value; b_sid = be.sid;
        #1;
        obs_ready = exe_ready;
        exp_ready = !r && (sbq.size() <= int'(DEPTH) - 2);
        acc = exp_ready;
        @(posedge clk);
        if (r) begin
            sbq.delete();
            exp_p = '0;
        end else begin
            n = (sbq.size() > 2) ? 2 : sbq.size();
            exp_p.v0 = 1'b0; exp_p.sv0 = 1'b0;
            exp_p.v1 = 1'b0; exp_p.sv1 = 1'b0;
            if (n >= 1) begin
                e0 = sbq.pop_front();
                exp_p.v0 = (e0.rd_type != 2'd0) && (e0.rd != 5'd0);
                exp_p.rd0 = e0.rd; exp_p.val0 = e0.value;
                exp_p.sv0 = 1'b1; exp_p.sid0 = e0.sid;
            end
            if (n == 2) begin
                e1 = sbq.pop_front();
                exp_p.v1 = (e1.rd_type != 2'd0) && (e1.rd != 5'd0);
                exp_p.rd1 = e1.rd; exp_p.val1 = e1.value;
                exp_p.sv1 = 1'b1; exp_p.sid1 = e1.sid;
                if (exp_p.v0 && exp_p.v1 && e0.rd == e1.rd) exp_p.v0 = 1'b0;
            end
            if (acc && av) sbq.push_back(ae);
            if (acc && bv) sbq.push_back(be);
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, '{2'd1, 5'd1, 64'h11, 6'd1}, 1'b1, '{2'd1, 5'd2, 64'h22, 6'd2});
            total++;
            if (dut_ports() !== ports_t'(0)) begin
                bad++; $display("FAIL reset_outputs: got %h want 0", dut_ports());
            end
            total++;
            if (obs_ready !== 1'b0) begin
                bad++; $display("FAIL reset_ready: got %b want 0", obs_ready);
            end
        end
        idle();
        total++;
        if (obs_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b want 1", obs_ready);
        end
        total++;
        if (dut_ports() !== exp_p) begin
            bad++; $display("FAIL reset_release_idle: got %h want %h", dut_ports(), exp_p);
        end
    endtask

    task automatic test_single();
        step(1'b0, 1'b1, '{2'd1, 5'd5, 64'h1234, 6'd3}, 1'b0, '0);
        total++;
        if (w0_v !== 1'b0 || s0_v !== 1'b0) begin
            bad++; $display("FAIL single_early: got v=%b sv=%b want 0 0", w0_v, s0_v);
        end
        idle();
        total++;
        if ({w0_v, w0_rd, w0_val, s0_v, s0_sid, w1_v, s1_v} !==
            {1'b1, 5'd5, 64'h1234, 1'b1, 6'd3, 1'b0, 1'b0}) begin
            bad++; $display("FAIL single_write: got v=%b rd=%0d val=%h sv=%b sid=%0d p1=%b%b",
                            w0_v, w0_rd, w0_val, s0_v, s0_sid, w1_v, s1_v);
        end
        total++;
        if (dut_ports() !== exp_p) begin
            bad++; $display("FAIL single_model: got %h want %h", dut_ports(), exp_p);
        end
        idle();
        total++;
        if (dut_ports() !== exp_p) begin
            bad++; $display("FAIL single_hold: got %h want %h", dut_ports(), exp_p);
        end
    endtask

    task automatic test_x0_nodest();
        step(1'b0, 1'b1, '{2'd1, 5'd0, 64'hFF, 6'd4}, 1'b1, '{2'd0, 5'd7, 64'h77, 6'd5});
        idle();
        total++;
        if ({w0_v, w1_v, s0_v, s0_sid, s1_v, s1_sid} !== {1'b0, 1'b0, 1'b1, 6'd4, 1'b1, 6'd5}) begin
            bad++; $display("FAIL x0_nodest: got v=%b%b sv0=%b sid0=%0d sv1=%b sid1=%0d",
                            w0_v, w1_v, s0_v, s0_sid, s1_v, s1_sid);
        end
        total++;
        if (dut_ports() !== exp_p) begin
            bad++; $display("FAIL x0_model: got %h want %h", dut_ports(), exp_p);
        end
    endtask

    task automatic test_collision();
        step(1'b0, 1'b1, '{2'd1, 5'd10, 64'hA, 6'd6}, 1'b1, '{2'd1, 5'd10, 64'hB, 6'd7});
        idle();
        total++;
        if ({w0_v, w1_v, w1_rd, w1_val, s0_v, s0_sid, s1_v, s1_sid} !==
            {1'b0, 1'b1, 5'd10, 64'hB, 1'b1, 6'd6, 1'b1, 6'd7}) begin
            bad++; $display("FAIL collision: got v=%b%b rd1=%0d val1=%h sids=%b%0d %b%0d",
                            w0_v, w1_v, w1_rd, w1_val, s0_v, s0_sid, s1_v, s1_sid);
        end
        total++;
        if (dut_ports() !== exp_p) begin
            bad++; $display("FAIL collision_model: got %h want %h", dut_ports(), exp_p);
        end
    endtask

    task automatic test_back_to_back();
        ent_t a, b;
        for (int i = 0; i < 12; i++) begin
            a = '{2'd1, 5'(2 * i + 1), 64'(32'hA000 + i), SID_W'(2 * i)};
            b = '{2'd1, 5'(2 * i + 2), 64'(32'hB000 + i), SID_W'(2 * i + 1)};
            step(1'b0, 1'b1, a, 1'b1, b);
            total++;
            if (obs_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, obs_ready);
            end
            total++;
            if (dut_ports() !== exp_p) begin
                bad++; $display("FAIL b2b_model[%0d]: got %h want %h", i, dut_ports(), exp_p);
            end
            if (i > 0) begin
                total++;
                if ({s0_v, s0_sid, s1_v, s1_sid} !==
                    {1'b1, SID_W'(2 * i - 2), 1'b1, SID_W'(2 * i - 1)}) begin
                    bad++; $display("FAIL b2b_order[%0d]: got %b%0d %b%0d want sids %0d %0d",
                                    i, s0_v, s0_sid, s1_v, s1_sid, 2 * i - 2, 2 * i - 1);
                end
            end
        end
        step(1'b0, 1'b0, '0, 1'b1, '{2'd1, 5'd9, 64'h2424, 6'd24});
        total++;
        if ({s0_v, s0_sid, s1_v, s1_sid} !== {1'b1, 6'd22, 1'b1, 6'd23}) begin
            bad++; $display("FAIL b2b_tail: got %b%0d %b%0d want sids 22 23", s0_v, s0_sid, s1_v, s1_sid);
        end
        idle();
        total++;
        if ({w0_v, w0_rd, w0_val, s0_v, s0_sid, w1_v, s1_v} !==
            {1'b1, 5'd9, 64'h2424, 1'b1, 6'd24, 1'b0, 1'b0}) begin
            bad++; $display("FAIL lane1_only: got v=%b rd=%0d val=%h sv=%b sid=%0d p1=%b%b",
                            w0_v, w0_rd, w0_val, s0_v, s0_sid, w1_v, s1_v);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, '{2'd1, 5'd3, 64'h33, 6'd10}, 1'b1, '{2'd1, 5'd4, 64'h44, 6'd11});
        step(1'b1, 1'b0, '0, 1'b0, '0);
        total++;
        if (dut_ports() !== ports_t'(0)) begin
            bad++; $display("FAIL midrst_clear: got %h want 0", dut_ports());
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            total++;
            if ({w0_v, w1_v, s0_v, s1_v} !== 4'b0000 || dut_ports() !== exp_p) begin
                bad++; $display("FAIL midrst_quiet[%0d]: got %h want %h", i, dut_ports(), exp_p);
            end
        end
        step(1'b0, 1'b1, '{2'd1, 5'd6, 64'h66, 6'd12}, 1'b0, '0);
        idle();
        total++;
        if ({w0_v, w0_rd, w0_val, s0_v, s0_sid, w1_v, s1_v} !==
            {1'b1, 5'd6, 64'h66, 1'b1, 6'd12, 1'b0, 1'b0}) begin
            bad++; $display("FAIL midrst_next: got v=%b rd=%0d val=%h sv=%b sid=%0d p1=%b%b",
                            w0_v, w0_rd, w0_val, s0_v, s0_sid, w1_v, s1_v);
        end
        idle();
        total++;
        if ({w0_v, w1_v, s0_v, s1_v} !== 4'b0000 || dut_ports() !== exp_p) begin
            bad++; $display("FAIL midrst_after: got %h want %h", dut_ports(), exp_p);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_x0_nodest();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
